// File: rtl/usbf_rx_pkt_dec_if.sv
// Byte stream from the UTMI receive side into the packet decoder, plus the
// decoded events and fields handed to the protocol engine.
interface usbf_rx_pkt_dec_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_active;
    logic        rx_err;

    logic [7:0]  pid;
    logic        pid_valid;
    logic        token_valid;
    logic [6:0]  token_addr;
    logic [3:0]  token_ep;
    logic [10:0] sof_frame;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_done;
    logic        pid_err;
    logic        crc5_err;
    logic        crc16_err;
    logic        seq_err;
    logic        busy;

    modport master (
        output rx_data, rx_valid, rx_active, rx_err,
        input  pid, pid_valid, token_valid, token_addr, token_ep, sof_frame,
               pl_data, pl_valid, pl_done, pid_err, crc5_err, crc16_err,
               seq_err, busy
    );

    modport slave (
        input  rx_data, rx_valid, rx_active, rx_err,
        output pid, pid_valid, token_valid, token_addr, token_ep, sof_frame,
               pl_data, pl_valid, pl_done, pid_err, crc5_err, crc16_err,
               seq_err, busy
    );
endinterface

// File: rtl/usbf_rx_pkt_dec.sv
// Receive packet decoder: PID check, token decode with CRC5, data payload
// streaming with CRC16 bytes stripped and checked, malformed-packet detection.
module usbf_rx_pkt_dec #(
    parameter int unsigned MAX_PL = 1024,
    parameter int unsigned CNT_W  = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    usbf_rx_pkt_dec_if.slave dec_if
);
    localparam logic [4:0]       CRC5_GOOD  = 5'b01100;
    localparam logic [15:0]      CRC16_GOOD = 16'h800D;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_PL + 2);
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DISCARD
    } state_t;

    state_t           state_q, state_d;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       h0_q, h0_d, h1_q, h1_d;
    logic [4:0]       crc5_q, crc5_d;
    logic [15:0]      crc16_q, crc16_d;
    logic [7:0]       pid_q, pid_d;
    logic [6:0]       addr_q, addr_d;
    logic [3:0]       ep_q, ep_d;
    logic [10:0]      sof_q, sof_d;
    logic [7:0]       pl_data_q, pl_data_d;
    logic             pid_valid_q, pid_valid_d, token_valid_q, token_valid_d;
    logic             pl_valid_q, pl_valid_d, pl_done_q, pl_done_d;
    logic             pid_err_q, pid_err_d, crc5_err_q, crc5_err_d;
    logic             crc16_err_q, crc16_err_d, seq_err_q, seq_err_d;
    logic             busy_q;
    logic             take_pid;
    logic [CNT_W-1:0] cnt_inc;

    // Serial CRCs, LSB of each byte first
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'h05;
            else             r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        h0_d          = h0_q;
        h1_d          = h1_q;
        crc5_d        = crc5_q;
        crc16_d       = crc16_q;
        pid_d         = pid_q;
        addr_d        = addr_q;
        ep_d          = ep_q;
        sof_d         = sof_q;
        pl_data_d     = pl_data_q;
        pid_valid_d   = 1'b0;
        token_valid_d = 1'b0;
        pl_valid_d    = 1'b0;
        pl_done_d     = 1'b0;
        pid_err_d     = 1'b0;
        crc5_err_d    = 1'b0;
        crc16_err_d   = 1'b0;
        seq_err_d     = 1'b0;
        take_pid      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // armed_q blocks the tail of a packet interrupted by reset
                if (dec_if.rx_active && armed_q) begin
                    state_d  = S_PID;
                    take_pid = dec_if.rx_valid;
                end
            end
            S_PID: begin
                if (!dec_if.rx_active) state_d = S_IDLE;
                else                   take_pid = dec_if.rx_valid;
            end
            S_TOKEN: begin
                if (dec_if.rx_valid) begin
                    cnt_d  = cnt_inc;
                    h0_d   = h1_q;
                    h1_d   = dec_if.rx_data;
                    crc5_d = crc5_byte(crc5_q, dec_if.rx_data);
                end
                if (!dec_if.rx_active) begin
                    state_d = S_IDLE;
                    if (cnt_d != CNT_TWO)         seq_err_d  = 1'b1;
                    else if (crc5_d != CRC5_GOOD) crc5_err_d = 1'b1;
                    else begin
                        token_valid_d = 1'b1;
                        addr_d        = h0_d[6:0];
                        ep_d          = {h1_d[2:0], h0_d[7]};
                        if (pid_q[3:0] == 4'h5) sof_d = {h1_d[2:0], h0_d};
                    end
                end
            end
            S_DATA: begin
                if (dec_if.rx_valid) begin
                    cnt_d   = cnt_inc;
                    crc16_d = crc16_byte(crc16_q, dec_if.rx_data);
                    if (cnt_d > CNT_MAX) begin
                        seq_err_d = 1'b1;
                        state_d   = S_DISCARD;
                    end else begin
                        // two-byte holding pipe keeps the CRC16 bytes from being emitted
                        if (cnt_q >= CNT_TWO) begin
                            pl_valid_d = 1'b1;
                            pl_data_d  = h0_q;
                        end
                        h0_d = h1_q;
                        h1_d = dec_if.rx_data;
                    end
                end
                if (!dec_if.rx_active && state_d != S_DISCARD) begin
                    state_d = S_IDLE;
                    if (cnt_d < CNT_TWO)             seq_err_d   = 1'b1;
                    else if (crc16_d != CRC16_GOOD)  crc16_err_d = 1'b1;
                    else                             pl_done_d   = 1'b1;
                end
            end
            S_HSK: begin
                if (dec_if.rx_valid) begin
                    seq_err_d = 1'b1;
                    state_d   = S_DISCARD;
                end else if (!dec_if.rx_active) begin
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!dec_if.rx_active) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (take_pid) begin
            cnt_d   = '0;
            crc5_d  = '1;
            crc16_d = '1;
            if (dec_if.rx_data[3:0] != ~dec_if.rx_data[7:4]) begin
                pid_err_d = 1'b1;
                state_d   = S_DISCARD;
            end else begin
                pid_d       = dec_if.rx_data;
                pid_valid_d = 1'b1;
                unique case (dec_if.rx_data[3:0])
                    4'h1, 4'h9, 4'hD, 4'h4, 4'h5: state_d = S_TOKEN;
                    4'h3, 4'hB, 4'h7, 4'hF:       state_d = S_DATA;
                    4'h2, 4'hA, 4'hE, 4'h6:       state_d = S_HSK;
                    default:                      state_d = S_DISCARD;
                endcase
            end
        end

        // PHY error aborts the packet; it owns the single error pulse
        if (dec_if.rx_err && state_q != S_IDLE && state_q != S_DISCARD) begin
            pid_d         = pid_q;
            addr_d        = addr_q;
            ep_d          = ep_q;
            sof_d         = sof_q;
            pl_data_d     = pl_data_q;
            pid_valid_d   = 1'b0;
            token_valid_d = 1'b0;
            pl_valid_d    = 1'b0;
            pl_done_d     = 1'b0;
            pid_err_d     = 1'b0;
            crc5_err_d    = 1'b0;
            crc16_err_d   = 1'b0;
            seq_err_d     = 1'b1;
            state_d       = S_DISCARD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            h0_q          <= '0;
            h1_q          <= '0;
            crc5_q        <= '1;
            crc16_q       <= '1;
            pid_q         <= '0;
            addr_q        <= '0;
            ep_q          <= '0;
            sof_q         <= '0;
            pl_data_q     <= '0;
            pid_valid_q   <= 1'b0;
            token_valid_q <= 1'b0;
            pl_valid_q    <= 1'b0;
            pl_done_q     <= 1'b0;
            pid_err_q     <= 1'b0;
            crc5_err_q    <= 1'b0;
            crc16_err_q   <= 1'b0;
            seq_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_q | ~dec_if.rx_active;
            cnt_q         <= cnt_d;
            h0_q          <= h0_d;
            h1_q          <= h1_d;
            crc5_q        <= crc5_d;
            crc16_q       <= crc16_d;
            pid_q         <= pid_d;
            addr_q        <= addr_d;
            ep_q          <= ep_d;
            sof_q         <= sof_d;
            pl_data_q     <= pl_data_d;
            pid_valid_q   <= pid_valid_d;
            token_valid_q <= token_valid_d;
            pl_valid_q    <= pl_valid_d;
            pl_done_q     <= pl_done_d;
            pid_err_q     <= pid_err_d;
            crc5_err_q    <= crc5_err_d;
            crc16_err_q   <= crc16_err_d;
            seq_err_q     <= seq_err_d;
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign dec_if.pid         = pid_q;
    assign dec_if.pid_valid   = pid_valid_q;
    assign dec_if.token_valid = token_valid_q;
    assign dec_if.token_addr  = addr_q;
    assign dec_if.token_ep    = ep_q;
    assign dec_if.sof_frame   = sof_q;
    assign dec_if.pl_data     = pl_data_q;
    assign dec_if.pl_valid    = pl_valid_q;
    assign dec_if.pl_done     = pl_done_q;
    assign dec_if.pid_err     = pid_err_q;
    assign dec_if.crc5_err    = crc5_err_q;
    assign dec_if.crc16_err   = crc16_err_q;
    assign dec_if.seq_err     = seq_err_q;
    assign dec_if.busy        = busy_q;
endmodule
